// File: rtl/prog_loader.sv
// Framed byte-stream loader: sync, 12-bit length, data bytes (written to instruction memory), optional checksum.
// Optional checksum byte enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader #(
  parameter int         DEPTH     = 2048,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [12:0] DEPTH_L = 13'(DEPTH);

  state_t      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic        rdy_q;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [11:0] len_full;
  logic        go_done, go_err;

  assign accept   = rx_valid && rdy_q;
  assign len_full = {len_q[11:8], rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    go_done = 1'b0;
    go_err  = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = {rx_data[3:0], 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          // Sum is cleared for the empty frame too so the checksum test sees zero.
          idx_d = '0;
          sum_d = '0;
          if ({1'b0, len_full} > DEPTH_L) begin
            go_err = 1'b1;
          end else if (len_full == 12'd0) begin
`ifdef PROG_LOADER_CSUM_EN
            state_d = CSUM;
`else
            go_done = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = rx_data;
          sum_d   = sum_q + rx_data;
          idx_d   = idx_q + 12'd1;
          if (idx_q == len_q - 12'd1) begin
`ifdef PROG_LOADER_CSUM_EN
            state_d = CSUM;
`else
            go_done = 1'b1;
`endif
          end
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      CSUM: begin
        if (accept) begin
          if (8'(sum_q + rx_data) == 8'h00) go_done = 1'b1;
          else                              go_err  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (go_done) begin
      state_d = DONE;
      done_d  = 1'b1;
      hold_d  = 1'b0;
    end
    if (go_err) begin
      state_d = ERR;
      err_d   = 1'b1;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      rdy_q   <= 1'b1;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_ready  = rdy_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames checked against a frame-level model.
module tb_prog_loader;
  localparam int         DEPTH = 2048;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, cpu_hold, done, error;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;

  prog_loader #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_d[$];
  logic        exp_done, exp_err;
  logic [11:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          cyc = 0;

  // Write monitor: records every strobe with the cycle it appeared in.
  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int gap_pct);
    for (int i = 0; i < tx_q.size(); i++) begin
      for (int g = 0; g < 3 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
      @(negedge clk);
      rx_data  = tx_q[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Reference: a frame is sync, length, len random bytes and (if enabled) the two's-complement checksum.
  task automatic make_frame(input int len, input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    tx_q.delete();
    exp_d.delete();
    tx_q.push_back(SYNC);
    tx_q.push_back({4'($urandom), 4'(len >> 8)});
    tx_q.push_back(8'(len));
    if (len > DEPTH) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    s = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      exp_d.push_back(b);
      tx_q.push_back(b);
      s = s + b;
    end
`ifdef PROG_LOADER_CSUM_EN
    tx_q.push_back(8'(8'h00 - s + (bad ? 8'h01 : 8'h00)));
    exp_done = !bad;
    exp_err  = bad;
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
`endif
  endtask

  task automatic run_frame(input string tag, input int gap_pct);
    int nbad;
    wa.delete(); wd.delete(); wc.delete();
    send(gap_pct);
    repeat (2) @(negedge clk);
    chk({tag, ".nwrites"}, 32'(wa.size()), 32'(exp_d.size()));
    nbad = 0;
    for (int i = 0; i < wa.size() && i < exp_d.size(); i++)
      if (wa[i] !== 12'(i) || wd[i] !== exp_d[i]) nbad++;
    chk({tag, ".writes"}, 32'(nbad), 32'd0);
    if (gap_pct == 0 && wc.size() > 1) begin
      nbad = 0;
      for (int i = 1; i < wc.size(); i++) if (wc[i] != wc[0] + i) nbad++;
      chk({tag, ".b2b"}, 32'(nbad), 32'd0);
    end
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
    chk({tag, ".error"}, 32'(error), 32'(exp_err));
    chk({tag, ".hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, ".we_idle"}, 32'(mem_we), 32'd0);
    if (exp_d.size() > 0) begin
      chk({tag, ".addr_hold"}, 32'(mem_addr), 32'(exp_d.size() - 1));
      chk({tag, ".wdata_hold"}, 32'(mem_wdata), 32'(exp_d[exp_d.size() - 1]));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.rx_ready", 32'(rx_ready), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    rst = 1'b0;
    chk("rel.rx_ready_low", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel.rx_ready_high", 32'(rx_ready), 32'd1);

    // Junk before sync, then an empty frame.
    tx_q = '{8'h00, 8'h7F, SYNC, 8'h00, 8'h00, 8'h00};
    exp_d.delete(); exp_done = 1'b1; exp_err = 1'b0;
    run_frame("empty", 0);

`ifdef PROG_LOADER_CSUM_EN
    tx_q = '{SYNC, 8'h00, 8'h02, 8'h10, 8'h20, 8'h00};
    exp_d = '{8'h10, 8'h20}; exp_done = 1'b0; exp_err = 1'b1;
    run_frame("badcsum", 0);
`endif

    // Sync value inside a frame is plain data; a good frame also clears a prior error.
    tx_q = '{SYNC, 8'h00, 8'h02, SYNC, SYNC};
`ifdef PROG_LOADER_CSUM_EN
    tx_q.push_back(8'hB6);
`endif
    exp_d = '{SYNC, SYNC}; exp_done = 1'b1; exp_err = 1'b0;
    run_frame("syncdata", 0);

    make_frame(2049, 1'b0);
    run_frame("len2049", 0);
    make_frame(4095, 1'b0);
    run_frame("len4095", 0);

    // Reset in the middle of a frame.
    tx_q = '{SYNC, 8'h00, 8'h04, 8'h11};
    send(0);
    chk("mid.hold", 32'(cpu_hold), 32'd1);
    chk("mid.done_cleared", 32'(done), 32'd0);
    chk("mid.we", 32'(mem_we), 32'd1);
    chk("mid.wdata", 32'(mem_wdata), 32'h11);
    #2 rst = 1'b1;
    #1;
    chk("arst.hold", 32'(cpu_hold), 32'd0);
    chk("arst.we", 32'(mem_we), 32'd0);
    chk("arst.wdata", 32'(mem_wdata), 32'd0);
    chk("arst.rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst.rx_ready_back", 32'(rx_ready), 32'd1);
    tx_q = '{SYNC, 8'h00, 8'h01, 8'h55};
`ifdef PROG_LOADER_CSUM_EN
    tx_q.push_back(8'hAB);
`endif
    exp_d = '{8'h55}; exp_done = 1'b1; exp_err = 1'b0;
    run_frame("after_rst", 0);

    make_frame(DEPTH, 1'b0);
    run_frame("len_depth", 0);

    for (int k = 0; k < 8; k++) begin
      make_frame($urandom_range(1, 40), $urandom_range(0, 3) == 0);
      run_frame($sformatf("rand%0d", k), (k % 2) ? 30 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
